// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential advance, conditional jumps, and call/return
// through a circular return-address stack with sticky overflow/underflow flags.

`ifndef STAGE_PC_UPDATE
`define STAGE_PC_UPDATE 3'd4
`endif
`ifndef INSTR_JUMP
`define INSTR_JUMP 5'd1
`endif
`ifndef INSTR_CALL
`define INSTR_CALL 5'd2
`endif
`ifndef INSTR_RET
`define INSTR_RET 5'd3
`endif

module pc_sequencer #(
  parameter int unsigned       WIDTH        = 32,
  parameter int unsigned       RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       INSTR_BYTES  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     stage,
  input  logic [4:0]                     current_instruction_type,
  input  logic [WIDTH-1:0]               jump_condition,
  input  logic [WIDTH-1:0]               jump_address,
  input  logic                           stall,
  output logic [WIDTH-1:0]               pc,
  output logic                           pc_en,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             update;
  logic             push;
  logic [WIDTH-1:0] seq_next;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign update   = (stage == `STAGE_PC_UPDATE) && !stall;
  assign seq_next = pc_q + WIDTH'(INSTR_BYTES);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    top_d = top_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (update) begin
      case (current_instruction_type)
        `INSTR_JUMP: begin
          pc_d = (jump_condition == WIDTH'(1)) ? jump_address : seq_next;
        end
        `INSTR_CALL: begin
          pc_d  = jump_address;
          push  = 1'b1;
          top_d = top_q + PW'(1);
          // When full, the write slot wraps onto the oldest entry.
          if (cnt_q == CW'(RAS_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        `INSTR_RET: begin
          if (cnt_q != '0) begin
            pc_d  = ras_mem[top_q];
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d  = seq_next;
            unf_d = 1'b1;
          end
        end
        default: begin
          pc_d = seq_next;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries are unobservable while the count is zero, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && rst) begin
      ras_mem[top_d] <= seq_next;
    end
  end

  assign pc            = pc_q;
  assign pc_en         = update;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
